zigzag_reorder: RTL and testbench

- Consumes 8x8 coefficient blocks delivered one row per beat on the transpose-memory output interface (8 parallel BW-bit lanes plus enable).
- Emits each block in zigzag scan order, 8 coefficients per beat, so that a downstream quantiser or entropy stage sees scan positions 0..63 in 8 beats.
- Double-buffered (ping-pong), so there is no throughput loss at one row per cycle.

---
 rtl/zigzag_reorder_if.sv | 27 ++
 rtl/zigzag_reorder.sv | 192 +++++++++++++++++++
 tb/tb_zigzag_reorder.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zigzag_reorder_if.sv
// Stream interface for zigzag_reorder: one row in per beat, one scan-ordered
// beat out. The design uses the slave modport and the source/sink uses master.
// Optional: ZZ_ALT_SCAN_EN adds the per-block i_alt select.
interface zigzag_reorder_if #(
    parameter int BW = 12
);
    logic [8*BW-1:0] i_data;
    logic            i_en;
`ifdef ZZ_ALT_SCAN_EN
    logic            i_alt;
`endif
    logic [8*BW-1:0] o_data;
    logic            o_en;
    logic            o_sob;

`ifdef ZZ_ALT_SCAN_EN
    modport master (output i_data, output i_en, output i_alt,
                    input  o_data, input  o_en, input  o_sob);
    modport slave  (input  i_data, input  i_en, input  i_alt,
                    output o_data, output o_en, output o_sob);
`else
    modport master (output i_data, output i_en,
                    input  o_data, input  o_en, input  o_sob);
    modport slave  (input  i_data, input  i_en,
                    output o_data, output o_en, output o_sob);
`endif
endinterface

// File: rtl/zigzag_reorder.sv
// zigzag_reorder: ping-pong 8x8 block buffer. Rows are written in natural
// order; each full bank is read out in 8 beats of 8 zigzag-ordered lanes.
// Optional: define ZZ_ALT_SCAN_EN to add a per-block column-first scan.
module zigzag_reorder #(
    parameter int BW = 12
) (
    input  logic           i_clk,
    input  logic           i_Reset,
    zigzag_reorder_if.slave bus
);
    // JPEG zigzag: scan position -> natural index (8*row + col)
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    genvar gi;

    // Storage: address = {bank, row, col}
    logic [BW-1:0]   r_bank [128];

    // Write side
    logic [2:0]      r_wr_row;
    logic            r_wr_bank;
    logic            w_wr_done;

    // Bank status
    logic [1:0]      r_full;
    logic [1:0]      w_full_next;
`ifdef ZZ_ALT_SCAN_EN
    logic [1:0]      r_alt;
`endif

    // Read side
    state_t          r_state;
    state_t          w_state_next;
    logic [2:0]      r_rd_beat;
    logic [2:0]      w_rd_beat_next;
    logic            r_rd_bank;
    logic            w_rd_bank_next;
    logic            w_emit;
    logic [2:0]      w_beat;
    logic            w_rd_done;

    // Lanes
    logic [BW-1:0]   w_in_lane [8];
    logic [8*BW-1:0] w_rd_row;

    // Registered outputs
    logic [8*BW-1:0] r_o_data;
    logic            r_o_en;
    logic            r_o_sob;

    assign w_wr_done = bus.i_en && (r_wr_row == 3'd7);

    // Per-lane input split and scan-order gather from the read bank
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [5:0] w_scan;
            logic [5:0] w_nat;
            logic [5:0] w_addr;

            assign w_in_lane[gi] = bus.i_data[(8-gi)*BW-1 -: BW];
            assign w_scan        = {w_beat, 3'(gi)};
            assign w_nat         = 6'(ZZ[w_scan]);
`ifdef ZZ_ALT_SCAN_EN
            // Column-first variant: swap row and column of the natural index
            assign w_addr = r_alt[r_rd_bank] ? {w_nat[2:0], w_nat[5:3]} : w_nat;
`else
            assign w_addr = w_nat;
`endif
            assign w_rd_row[(8-gi)*BW-1 -: BW] = r_bank[{r_rd_bank, w_addr}];
        end
    endgenerate

    // Row write into the current write bank; contents need no reset
    always_ff @(posedge i_clk) begin
        if (!i_Reset && bus.i_en) begin
            for (int c = 0; c < 8; c++) begin
                r_bank[{r_wr_bank, r_wr_row, 3'(c)}] <= w_in_lane[c];
            end
        end
    end

    // Write row counter and bank toggle; framing is purely by beat count
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_wr_row  <= 3'd0;
            r_wr_bank <= 1'b0;
        end else if (bus.i_en) begin
            r_wr_row <= r_wr_row + 3'd1;
            if (w_wr_done) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

`ifdef ZZ_ALT_SCAN_EN
    // Scan select is captured with row 0 and travels with the bank
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_alt <= 2'b00;
        end else if (bus.i_en && (r_wr_row == 3'd0)) begin
            r_alt[r_wr_bank] <= bus.i_alt;
        end
    end
`endif

    // Read FSM next state: beat 0 leaves IDLE directly, beat 7 frees the bank
    always_comb begin
        w_state_next   = r_state;
        w_rd_beat_next = r_rd_beat;
        w_rd_bank_next = r_rd_bank;
        w_emit         = 1'b0;
        w_beat         = r_rd_beat;
        w_rd_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_beat = 3'd0;
                if (r_full[r_rd_bank]) begin
                    w_emit         = 1'b1;
                    w_rd_beat_next = 3'd1;
                    w_state_next   = ST_READ;
                end
            end
            ST_READ: begin
                w_emit         = 1'b1;
                w_rd_beat_next = r_rd_beat + 3'd1;
                if (r_rd_beat == 3'd7) begin
                    w_rd_done      = 1'b1;
                    w_rd_bank_next = ~r_rd_bank;
                    // Counter wraps to 0, so a waiting bank streams on seamlessly
                    w_state_next   = r_full[~r_rd_bank] ? ST_READ : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Full flags: set by the last row write, cleared by the last readout beat
    always_comb begin
        w_full_next = r_full;
        if (w_rd_done) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
        if (w_wr_done) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
    end

    // Read FSM and bank status registers
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_state   <= ST_IDLE;
            r_rd_beat <= 3'd0;
            r_rd_bank <= 1'b0;
            r_full    <= 2'b00;
        end else begin
            r_state   <= w_state_next;
            r_rd_beat <= w_rd_beat_next;
            r_rd_bank <= w_rd_bank_next;
            r_full    <= w_full_next;
        end
    end

    // Output register; data is forced to zero whenever no beat is valid
    always_ff @(posedge i_clk) begin
        if (i_Reset) begin
            r_o_data <= '0;
            r_o_en   <= 1'b0;
            r_o_sob  <= 1'b0;
        end else begin
            r_o_data <= w_emit ? w_rd_row : '0;
            r_o_en   <= w_emit;
            r_o_sob  <= w_emit && (w_beat == 3'd0);
        end
    end

    assign bus.o_data = r_o_data;
    assign bus.o_en   = r_o_en;
    assign bus.o_sob  = r_o_sob;

endmodule

// File: tb/tb_zigzag_reorder.sv
// Bench for zigzag_reorder: per-cycle comparison against a block-level model
// that schedules each completed block's scan-ordered beats by cycle number.
module tb_zigzag_reorder;
    localparam int BW = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    zigzag_reorder_if #(.BW(BW)) bus ();

    zigzag_reorder #(.BW(BW)) dut (
        .i_clk   (clk),
        .i_Reset (rst),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int zz_tab [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // Model state: expected output per cycle number
    logic [8*BW-1:0] exp_data [int];
    bit              exp_sob  [int];
    logic [BW-1:0]   blk [64];
    int              blk_cnt    = 0;
    bit              blk_alt    = 1'b0;
    int              last_start = -100;

    logic [8*BW+1:0] got, want;

    function automatic logic [8*BW+1:0] exp_word(input int c);
        if (exp_data.exists(c)) return {1'b1, exp_sob[c], exp_data[c]};
        return '0;
    endfunction

    function automatic logic [8*BW-1:0] ramp_row(input int base, input int r);
        logic [8*BW-1:0] v;
        for (int c = 0; c < 8; c++) v[(8-c)*BW-1 -: BW] = BW'(base + 8*r + c);
        return v;
    endfunction

    function automatic logic [8*BW-1:0] rand_row();
        logic [8*BW-1:0] v;
        for (int c = 0; c < 8; c++) v[(8-c)*BW-1 -: BW] = BW'($urandom);
        return v;
    endfunction

    function automatic logic [8*BW-1:0] pack8(input int v0, input int v1, input int v2,
                                              input int v3, input int v4, input int v5,
                                              input int v6, input int v7);
        return {BW'(v0), BW'(v1), BW'(v2), BW'(v3), BW'(v4), BW'(v5), BW'(v6), BW'(v7)};
    endfunction

    // One clock cycle: drive inputs for cycle cyc, update the model, stop mid-cycle
    task automatic tick(input bit r, input bit en, input logic [8*BW-1:0] d, input bit alt);
        int start;
        int n;
        int ks[$];
        logic [8*BW-1:0] w;
        @(posedge clk);
        #1;
        cyc++;
        rst         = r;
        bus.i_en    = en;
        bus.i_data  = en ? d : '0;
`ifdef ZZ_ALT_SCAN_EN
        bus.i_alt   = alt;
`endif
        if (r) begin
            blk_cnt    = 0;
            last_start = -100;
            foreach (exp_data[k]) if (k > cyc) ks.push_back(k);
            foreach (ks[i]) begin
                exp_data.delete(ks[i]);
                exp_sob.delete(ks[i]);
            end
        end else if (en) begin
            if (blk_cnt == 0) blk_alt = alt;
            for (int c = 0; c < 8; c++) blk[8*blk_cnt + c] = d[(8-c)*BW-1 -: BW];
            blk_cnt++;
            if (blk_cnt == 8) begin
                start = (cyc + 2 > last_start + 8) ? cyc + 2 : last_start + 8;
                for (int k = 0; k < 8; k++) begin
                    for (int j = 0; j < 8; j++) begin
                        n = zz_tab[8*k + j];
                        if (blk_alt) n = 8*(n % 8) + n / 8;
                        w[(8-j)*BW-1 -: BW] = blk[n];
                    end
                    exp_data[start + k] = w;
                    exp_sob[start + k]  = (k == 0);
                end
                last_start = start;
                blk_cnt    = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = '0; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_basic();
        int base;
        int n_en  = 0;
        int n_sob = 0;
        logic [8*BW-1:0] b0, b7;
        b0   = pack8(0, 1, 8, 16, 9, 2, 3, 10);
        b7   = pack8(53, 60, 61, 54, 47, 55, 62, 63);
        base = cyc;
        for (int i = 0; i < 20; i++) begin
            if (i < 8) tick(1'b0, 1'b1, ramp_row(0, i), 1'b0);
            else       tick(1'b0, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL basic cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (bus.o_en === 1'b1) n_en++;
            if (bus.o_sob === 1'b1) n_sob++;
            if (cyc == base + 10) begin
                checks++;
                if (bus.o_data !== b0 || bus.o_sob !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_beat0 got=%h sob=%b want=%h sob=1", bus.o_data, bus.o_sob, b0);
                end
            end
            if (cyc == base + 17) begin
                checks++;
                if (bus.o_data !== b7 || bus.o_en !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_beat7 got=%h en=%b want=%h en=1", bus.o_data, bus.o_en, b7);
                end
            end
        end
        checks++;
        if (n_en != 8 || n_sob != 1) begin
            errors++;
            $display("FAIL basic_counts got en=%0d sob=%0d want en=8 sob=1", n_en, n_sob);
        end
    endtask

    task automatic test_back_to_back();
        int n_en     = 0;
        int n_sob    = 0;
        int first_en = -1;
        int last_en  = -1;
        for (int i = 0; i < 44; i++) begin
            if (i < 32) tick(1'b0, 1'b1, ramp_row(64*(i/8), i%8), 1'b0);
            else        tick(1'b0, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (bus.o_en === 1'b1) begin
                n_en++;
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
            end
            if (bus.o_sob === 1'b1) n_sob++;
        end
        checks++;
        if (n_en != 32 || n_sob != 4 || last_en - first_en != 31) begin
            errors++;
            $display("FAIL back_to_back_run got en=%0d sob=%0d span=%0d want 32 4 31",
                     n_en, n_sob, last_en - first_en);
        end
    endtask

    task automatic test_gaps();
        int rows = 0;
        bit en;
        bit alt;
        alt = 1'b0;
        for (int i = 0; i < 200 && rows < 24; i++) begin
            en = ($urandom_range(0, 2) == 0);
            if (en && (rows % 8 == 0)) alt = 1'($urandom);
`ifndef ZZ_ALT_SCAN_EN
            alt = 1'b0;
`endif
            tick(1'b0, en, rand_row(), alt);
            if (en) rows++;
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL gaps cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL gaps_drain cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        for (int i = 0; i < 26; i++) begin
            if (i < 5)       tick(1'b0, 1'b1, rand_row(), 1'b0);
            else if (i == 5) tick(1'b1, 1'b0, '0, 1'b0);
            else if (i < 14) tick(1'b0, 1'b1, ramp_row(100, i - 6), 1'b0);
            else             tick(1'b0, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_write cyc=%0d got=%h want=%h", cyc, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        for (int i = 0; i < 24; i++) begin
            // rows in i=0..7, beat 0 visible at i=9, beat 3 visible at i=12
            if (i < 8)        tick(1'b0, 1'b1, ramp_row(200, i), 1'b0);
            else if (i == 12) tick(1'b1, 1'b0, '0, 1'b0);
            else              tick(1'b0, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_read cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (i == 13) begin
                checks++;
                if (bus.o_en !== 1'b0 || bus.o_data !== '0) begin
                    errors++;
                    $display("FAIL reset_mid_read_abort got en=%b data=%h want en=0 data=0",
                             bus.o_en, bus.o_data);
                end
            end
        end
    endtask

`ifdef ZZ_ALT_SCAN_EN
    task automatic test_alt();
        int base;
        logic [8*BW-1:0] a0, j0;
        a0   = pack8(0, 8, 1, 2, 9, 16, 24, 17);
        j0   = pack8(0, 1, 8, 16, 9, 2, 3, 10);
        base = cyc;
        for (int i = 0; i < 30; i++) begin
            if (i < 16) tick(1'b0, 1'b1, ramp_row(0, i % 8), (i < 8));
            else        tick(1'b0, 1'b0, '0, 1'b0);
            got = {bus.o_en, bus.o_sob, bus.o_data}; want = exp_word(cyc); checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL alt cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (cyc == base + 10) begin
                checks++;
                if (bus.o_data !== a0) begin
                    errors++;
                    $display("FAIL alt_block0 got=%h want=%h", bus.o_data, a0);
                end
            end
            if (cyc == base + 18) begin
                checks++;
                if (bus.o_data !== j0) begin
                    errors++;
                    $display("FAIL alt_block1 got=%h want=%h", bus.o_data, j0);
                end
            end
        end
    endtask
`endif

    // Writing into a bank that is still awaiting readout must never happen
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.i_en === 1'b1) begin
            checks++;
            if (dut.r_full[dut.r_wr_bank] !== 1'b0) begin
                errors++;
                $display("FAIL write_into_full cyc=%0d got full=1 want full=0", cyc);
            end
        end
    end

    // One line per output beat
    always @(negedge clk) begin
        if (bus.o_en === 1'b1) $display("beat cyc=%0d sob=%0b data=%h", cyc, bus.o_sob, bus.o_data);
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        bus.i_en   = 1'b0;
        bus.i_data = '0;
`ifdef ZZ_ALT_SCAN_EN
        bus.i_alt  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_gaps();
        test_reset_mid_write();
        test_reset_mid_read();
`ifdef ZZ_ALT_SCAN_EN
        test_alt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
